// File: rtl/stack_io_pkg.sv
// Shared constants for the stack processor host I/O bridge.
// Holds the state encodings, the fault cause codes and the default data width.
package stack_io_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] ST_BOOT  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;

  localparam logic CAUSE_OVF = 1'b0;
  localparam logic CAUSE_OVR = 1'b1;

endpackage

// File: rtl/io_out_fifo.sv
// Synchronous output FIFO. A write lands one cycle after push; head is read combinationally.
// A push while full is dropped unless it coincides with a pop; a pop while empty is ignored.
module io_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // At full, a push is legal only when a pop frees the slot in the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stack_io_bridge.sv
// Host I/O front end: boot gating of the processor, output change capture, sticky fault trap.
// Accepted input visible next cycle; host_in_ready drops only in FAULT; output FIFO drains via valid/ready.
module stack_io_bridge
  import stack_io_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] host_in_data,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  output logic [WIDTH-1:0] cpu_input_IO,
  input  logic [WIDTH-1:0] cpu_output_IO,
  input  logic             cpu_overflow,
  output logic             cpu_reset,
  output logic [WIDTH-1:0] host_out_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  output logic             fault,
  output logic             fault_cause,
  input  logic             fault_clr,
  output logic [1:0]       state
);

  logic [WIDTH-1:0] last_out;
  logic             accept;
  logic             push_req;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overrun;

  assign host_in_ready  = (state != ST_FAULT);
  assign cpu_reset      = (state != ST_RUN);
  assign accept         = host_in_valid && host_in_ready;
  assign host_out_valid = !fifo_empty;
  assign pop            = host_out_valid && host_out_ready;
  assign push_req       = (state == ST_RUN) && (cpu_output_IO != last_out);
  assign overrun        = push_req && fifo_full && !pop;

  io_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_req),
    .wr_data (cpu_output_IO),
    .pop     (pop),
    .head    (host_out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_BOOT;
      cpu_input_IO <= '0;
      last_out     <= '0;
      fault        <= 1'b0;
      fault_cause  <= CAUSE_OVF;
    end else begin
      case (state)
        ST_BOOT: begin
          // Track outputs while the processor is held in reset so they never push.
          last_out <= cpu_output_IO;
          if (accept) begin
            cpu_input_IO <= host_in_data;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            cpu_input_IO <= host_in_data;
          end
          if (push_req) begin
            last_out <= cpu_output_IO;
          end
          if (cpu_overflow) begin
            state       <= ST_FAULT;
            fault       <= 1'b1;
            fault_cause <= CAUSE_OVF;
          end else if (overrun) begin
            state       <= ST_FAULT;
            fault       <= 1'b1;
            fault_cause <= CAUSE_OVR;
          end
        end
        ST_FAULT: begin
          last_out <= cpu_output_IO;
          if (fault_clr) begin
            state        <= ST_BOOT;
            fault        <= 1'b0;
            cpu_input_IO <= '0;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_io_bridge.sv
// Directed bench for stack_io_bridge: a vector table for the main flow plus hand sequences
// for the full-FIFO boundary, simultaneous faults, fault_clr outside FAULT and mid-run reset.
module tb_stack_io_bridge;
  import stack_io_pkg::*;

  localparam int W = 16;
  localparam int D = 4;
  localparam int NV = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  host_in_data;
  logic          host_in_valid;
  logic          host_in_ready;
  logic [W-1:0]  cpu_input_IO;
  logic [W-1:0]  cpu_output_IO;
  logic          cpu_overflow;
  logic          cpu_reset;
  logic [W-1:0]  host_out_data;
  logic          host_out_valid;
  logic          host_out_ready;
  logic          fault;
  logic          fault_cause;
  logic          fault_clr;
  logic [1:0]    state;

  always #5 clk = ~clk;

  stack_io_bridge #(.WIDTH(W), .DEPTH(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .cpu_input_IO   (cpu_input_IO),
    .cpu_output_IO  (cpu_output_IO),
    .cpu_overflow   (cpu_overflow),
    .cpu_reset      (cpu_reset),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .fault          (fault),
    .fault_cause    (fault_cause),
    .fault_clr      (fault_clr),
    .state          (state)
  );

  typedef struct {
    logic         rst;
    logic [15:0]  din;
    logic         dvld;
    logic [15:0]  cout;
    logic         ovf;
    logic         ordy;
    logic         clr;
    logic         e_rdy;
    logic [15:0]  e_in;
    logic         e_crst;
    logic         e_ovld;
    logic [15:0]  e_odat;
    logic         e_fault;
    logic         e_cause;
    logic [1:0]   e_st;
  } vec_t;

  vec_t tbl [NV];
  int n_chk = 0;
  int n_pass = 0;

  function automatic vec_t mk(
    input logic rst, input logic [15:0] din, input logic dvld, input logic [15:0] cout,
    input logic ovf, input logic ordy, input logic clr,
    input logic e_rdy, input logic [15:0] e_in, input logic e_crst, input logic e_ovld,
    input logic [15:0] e_odat, input logic e_fault, input logic e_cause, input logic [1:0] e_st);
    vec_t v;
    v.rst = rst; v.din = din; v.dvld = dvld; v.cout = cout; v.ovf = ovf;
    v.ordy = ordy; v.clr = clr; v.e_rdy = e_rdy; v.e_in = e_in; v.e_crst = e_crst;
    v.e_ovld = e_ovld; v.e_odat = e_odat; v.e_fault = e_fault; v.e_cause = e_cause;
    v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] cout, input logic ordy);
    cpu_output_IO  = cout;
    host_out_ready = ordy;
    step();
  endtask

  initial begin
    reset = 1'b0; host_in_data = '0; host_in_valid = 1'b0; cpu_output_IO = '0;
    cpu_overflow = 1'b0; host_out_ready = 1'b0; fault_clr = 1'b0;

    //              rst din    dv cout   ov rd cl | rdy in     crs ov odat   flt cau st
    tbl[0]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 1, 0, 16'h0000, 0, 0, ST_BOOT);
    tbl[1]  = mk(1, 16'h1234, 1, 16'h0000, 0, 0, 0, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, ST_RUN);
    tbl[2]  = mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, ST_RUN);
    tbl[3]  = mk(1, 16'h0000, 0, 16'h00AA, 0, 1, 0, 1, 16'h1234, 0, 1, 16'h00AA, 0, 0, ST_RUN);
    tbl[4]  = mk(1, 16'h0000, 0, 16'h00AA, 0, 1, 0, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, ST_RUN);
    tbl[5]  = mk(1, 16'h0000, 0, 16'h0055, 0, 1, 0, 1, 16'h1234, 0, 1, 16'h0055, 0, 0, ST_RUN);
    tbl[6]  = mk(1, 16'h0000, 0, 16'h0055, 0, 1, 0, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, ST_RUN);
    tbl[7]  = mk(1, 16'h0000, 0, 16'h0001, 0, 0, 0, 1, 16'h1234, 0, 1, 16'h0001, 0, 0, ST_RUN);
    tbl[8]  = mk(1, 16'h0000, 0, 16'h0002, 0, 0, 0, 1, 16'h1234, 0, 1, 16'h0001, 0, 0, ST_RUN);
    tbl[9]  = mk(1, 16'h0000, 0, 16'h0003, 0, 0, 0, 1, 16'h1234, 0, 1, 16'h0001, 0, 0, ST_RUN);
    tbl[10] = mk(1, 16'h0000, 0, 16'h0004, 0, 0, 0, 1, 16'h1234, 0, 1, 16'h0001, 0, 0, ST_RUN);
    tbl[11] = mk(1, 16'h0000, 0, 16'h0005, 0, 0, 0, 0, 16'h1234, 1, 1, 16'h0001, 1, 1, ST_FAULT);
    tbl[12] = mk(1, 16'h0000, 0, 16'h0005, 0, 1, 0, 0, 16'h1234, 1, 1, 16'h0002, 1, 1, ST_FAULT);
    tbl[13] = mk(1, 16'hBEEF, 1, 16'h0005, 0, 1, 0, 0, 16'h1234, 1, 1, 16'h0003, 1, 1, ST_FAULT);
    tbl[14] = mk(1, 16'h0000, 0, 16'h0005, 0, 1, 0, 0, 16'h1234, 1, 1, 16'h0004, 1, 1, ST_FAULT);
    tbl[15] = mk(1, 16'h0000, 0, 16'h0005, 0, 1, 0, 0, 16'h1234, 1, 0, 16'h0000, 1, 1, ST_FAULT);
    tbl[16] = mk(1, 16'h0000, 0, 16'h0005, 0, 0, 1, 1, 16'h0000, 1, 0, 16'h0000, 0, 1, ST_BOOT);
    tbl[17] = mk(1, 16'h0001, 1, 16'h0005, 0, 0, 0, 1, 16'h0001, 0, 0, 16'h0000, 0, 1, ST_RUN);
    tbl[18] = mk(1, 16'h0000, 0, 16'h0005, 1, 0, 0, 0, 16'h0001, 1, 0, 16'h0000, 1, 0, ST_FAULT);
    tbl[19] = mk(1, 16'h0000, 0, 16'h0005, 0, 0, 1, 1, 16'h0000, 1, 0, 16'h0000, 0, 0, ST_BOOT);
    tbl[20] = mk(1, 16'h0001, 1, 16'h0005, 0, 0, 0, 1, 16'h0001, 0, 0, 16'h0000, 0, 0, ST_RUN);

    step();
    for (int i = 0; i < NV; i++) begin
      reset = tbl[i].rst; host_in_data = tbl[i].din; host_in_valid = tbl[i].dvld;
      cpu_output_IO = tbl[i].cout; cpu_overflow = tbl[i].ovf;
      host_out_ready = tbl[i].ordy; fault_clr = tbl[i].clr;
      step();
      // Head data is only meaningful while valid is expected.
      chk($sformatf("vec%0d {rdy,in,crst,ovld,odat,flt,cause,st}", i),
          {25'd0, host_in_ready, cpu_input_IO, cpu_reset, host_out_valid,
           (tbl[i].e_ovld ? host_out_data : 16'h0000), fault, fault_cause, state},
          {25'd0, tbl[i].e_rdy, tbl[i].e_in, tbl[i].e_crst, tbl[i].e_ovld,
           tbl[i].e_odat, tbl[i].e_fault, tbl[i].e_cause, tbl[i].e_st});
    end
    host_in_valid = 1'b0; fault_clr = 1'b0; cpu_overflow = 1'b0;

    // Full boundary: fill, then push and pop together at full.
    for (int k = 0; k < 4; k++) drive(16'h0010 + 16'(k), 1'b0);
    chk("full_head", {47'd0, host_out_valid, host_out_data}, {47'd0, 1'b1, 16'h0010});
    drive(16'h0014, 1'b1);
    chk("full_pushpop_nofault", {61'd0, fault, state}, {61'd0, 1'b0, ST_RUN});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_drain%0d", k), {47'd0, host_out_valid, host_out_data},
          {47'd0, 1'b1, 16'h0011 + 16'(k)});
      drive(16'h0014, 1'b1);
    end
    chk("full_drain_empty", {63'd0, host_out_valid}, 64'd0);

    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_ignored_in_run", {61'd0, fault, state}, {61'd0, 1'b0, ST_RUN});

    // Overflow and overrun at the same edge: overflow wins.
    for (int k = 0; k < 4; k++) drive(16'h0020 + 16'(k), 1'b0);
    cpu_overflow = 1'b1;
    drive(16'h0024, 1'b0);
    cpu_overflow = 1'b0;
    chk("both_fault", {60'd0, fault, fault_cause, state}, {60'd0, 1'b1, CAUSE_OVF, ST_FAULT});
    for (int k = 0; k < 4; k++) drive(16'h0024, 1'b1);
    chk("both_dropped_push", {63'd0, host_out_valid}, 64'd0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    host_in_data = 16'h0007; host_in_valid = 1'b1;
    step();
    host_in_valid = 1'b0;
    chk("rerun", {45'd0, cpu_reset, cpu_input_IO, state}, {45'd0, 1'b0, 16'h0007, ST_RUN});

    // Reset with three words queued and a pending push, pop and accept.
    for (int k = 0; k < 3; k++) drive(16'h0030 + 16'(k), 1'b0);
    chk("pre_reset_head", {47'd0, host_out_valid, host_out_data}, {47'd0, 1'b1, 16'h0030});
    reset = 1'b0; host_in_data = 16'h0009; host_in_valid = 1'b1;
    drive(16'h0033, 1'b1);
    chk("mid_reset", {42'd0, host_in_ready, cpu_input_IO, cpu_reset, host_out_valid,
                      fault, fault_cause, state},
        {42'd0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, ST_BOOT});
    reset = 1'b1; host_in_valid = 1'b0;
    drive(16'h0033, 1'b0);
    chk("post_reset_boot_nopush", {61'd0, host_out_valid, state}, {61'd0, 1'b0, ST_BOOT});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stack_io_bridge.md
# stack_io_bridge

Host-side I/O front end for the stack processor top level. It owns the processor's 16-bit `input_IO` word and holds the processor in reset until the host supplies a first input word. It captures every change of the processor's `output_IO` into a small FIFO drained over a valid/ready link. It also traps arithmetic `overflow` and FIFO overrun into a sticky fault that halts the processor until the host clears it.

## Interface
Parameters:
- `WIDTH`, default 16: data width; must equal the processor I/O width.
- `DEPTH`, default 4: output FIFO entries; must be a power of 2, at least 2.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-low reset.
- `host_in_data`  in  WIDTH  word offered by the host.
- `host_in_valid`  in  1  host offers `host_in_data`.
- `host_in_ready`  out  1  bridge accepts a word this cycle.
- `cpu_input_IO`  out  WIDTH  drives the processor `input_IO`.
- `cpu_output_IO`  in  WIDTH  from the processor `output_IO`.
- `cpu_overflow`  in  1  from the processor `overflow`.
- `cpu_reset`  out  1  active-high reset to the processor.
- `host_out_data`  out  WIDTH  FIFO head word.
- `host_out_valid`  out  1  FIFO non-empty.
- `host_out_ready`  in  1  host consumes the head word.
- `fault`  out  1  sticky fault flag.
- `fault_cause`  out  1  0 = overflow, 1 = FIFO overrun.
- `fault_clr`  in  1  host acknowledges the fault.
- `state`  out  2  BOOT=00, RUN=01, FAULT=10.

## Operation
Reset (`reset`=0 at a clk edge) loads:
- state=BOOT, `cpu_reset`=1, `cpu_input_IO`=0, `last_out`=0.
- FIFO empty, `host_out_valid`=0, `fault`=0, `fault_cause`=0.
- `host_in_ready`=1.

Accept: `host_in_valid && host_in_ready` at an edge.
- `host_in_ready` = (state != FAULT). It is combinational from state only.
- Accept in BOOT: `cpu_input_IO` ← data, state → RUN.
- Accept in RUN: `cpu_input_IO` ← data. Last accepted word wins.

Output capture:
- Applies only in RUN.
- Push when `cpu_output_IO != last_out`; `last_out` ← `cpu_output_IO` on every push.
- Repeated writes of the same value produce no push.
- In BOOT and FAULT, `last_out` ← `cpu_output_IO` every cycle, so reset-state outputs never push.

FIFO:
- Pop when `host_out_valid && host_out_ready`.
- Push and pop in the same cycle are legal at any occupancy, including full.
- Push while full without a pop drops the word and raises the overrun fault.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.

Fault entry (RUN only):
- `cpu_overflow`=1 → FAULT with cause 0.
- Overrun → FAULT with cause 1.
- Both in the same cycle → cause 0.
- Entry sets `fault`=1 and `fault_cause`.

In FAULT:
- `cpu_reset`=1, no pushes, no input accepts.
- The FIFO keeps draining to the host.

Fault clear:
- `fault_clr`=1 in FAULT → BOOT, `fault`=0, `cpu_input_IO`=0. FIFO contents are preserved.
- `fault_clr` is ignored outside FAULT.

`cpu_reset` = (state != RUN), decoded from the state register.

## Timing
- Input acceptance: an accept at edge N makes `cpu_input_IO` valid from cycle N+1. In BOOT, `cpu_reset` falls in cycle N+1.
- Output latency: a change of `cpu_output_IO` sampled at edge N raises `host_out_valid` in cycle N+1 when the FIFO was empty.
- FIFO read: `host_out_data` is the head entry, combinational from the read pointer. It is stable while valid is high and ready is low.
- Fault latency: overflow or overrun at edge N gives `fault`=1 and `cpu_reset`=1 in cycle N+1. A push that would overrun is discarded.
- Fault clear: asserting `fault_clr` at edge N gives state=BOOT in cycle N+1. The earliest possible RUN is cycle N+2.
- Reset priority: reset mid-operation overrides every other event at that edge, including a pending push, pop or accept.

## Structure
- Shared package `stack_io_pkg` holds:
  - state encodings `ST_BOOT`, `ST_RUN`, `ST_FAULT`;
  - cause constants `CAUSE_OVF`=0, `CAUSE_OVR`=1;
  - the default `WIDTH`.
- The natural sub-module is `io_out_fifo`: a synchronous FIFO with `push`, `pop`, `full`, `empty`, `head` and the same clk/reset.
- The top level holds the state register, the `last_out` compare, the input register and the fault logic.

## Test plan
- Boot release: after reset, send 0x1234 → `cpu_input_IO`=0x1234 and `cpu_reset`=0 one cycle later, state=01.
- Output capture: in RUN, drive `cpu_output_IO` 0x0000→0x00AA→0x00AA→0x0055 with `host_out_ready`=1 → host sees exactly 0x00AA, then 0x0055, each one cycle after its change.
- Overrun at DEPTH=4: hold `host_out_ready`=0 and drive 5 distinct values. Expect 4 values stored, then `fault`=1 and `fault_cause`=1, then `cpu_reset`=1. Release ready → the 4 values drain in order.
- Full boundary: FIFO full with push and pop in the same cycle → no fault, count stays 4, order preserved.
- Overflow trap: `cpu_overflow` pulses in RUN → FAULT with cause 0 and `host_in_ready`=0. `fault_clr` → BOOT and `cpu_input_IO`=0. A new word 0x0001 returns the bridge to RUN.
- Reset mid-run: assert `reset`=0 with FIFO count 3 → next cycle the FIFO is empty, state=BOOT, all outputs at reset values.
